rca_config_bank: RTL and testbench

//  Multi-context, double-buffered configuration store for the reconfigurable accelerators (RCAs).

---
 rtl/rca_config_bank.sv | 180 ++++++++++++++++++
 tb/tb_rca_config_bank.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_config_bank.sv
// Per-RCA double-buffered config store: shadow sets written any time, commit copies shadow->active once the RCA is idle.
// Reads are combinational from active[rca_sel]; the copy and ack land one edge after WAIT sees the RCA idle; only writes to the committing RCA stall.
module rca_config_bank #(
  parameter int unsigned NUM_RCAS           = 4,
  parameter int unsigned NUM_READ_PORTS     = 2,
  parameter int unsigned NUM_WRITE_PORTS    = 2,
  parameter int unsigned NUM_GRID_MUXES     = 32,
  parameter int unsigned GRID_MUX_INPUTS    = 8,
  parameter int unsigned GRID_NUM_ROWS      = 4,
  parameter int unsigned IO_UNIT_MUX_INPUTS = 8,
  parameter int unsigned CFG_DATA_W         = 8,
  localparam int unsigned RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int unsigned GW    = $clog2(GRID_MUX_INPUTS),
  localparam int unsigned RW    = $clog2(GRID_NUM_ROWS),
  localparam int unsigned IW    = $clog2(IO_UNIT_MUX_INPUTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_wr_valid,
  output logic                              cfg_wr_ready,
  input  logic [RCA_W-1:0]                  cfg_wr_rca,
  input  logic [2:0]                        cfg_wr_field,
  input  logic [7:0]                        cfg_wr_idx,
  input  logic [CFG_DATA_W-1:0]             cfg_wr_data,
  output logic                              cfg_wr_err,
  input  logic                              commit_req,
  input  logic [RCA_W-1:0]                  commit_rca,
  output logic                              commit_ack,
  output logic                              commit_busy,
  input  logic [NUM_RCAS-1:0]               rca_busy,
  input  logic [RCA_W-1:0]                  rca_sel,
  input  logic                              rca_use_fb_instr,
  output logic [NUM_READ_PORTS*5-1:0]       rca_cpu_src_reg_addrs,
  output logic [NUM_WRITE_PORTS*5-1:0]      rca_cpu_dest_reg_addrs,
  output logic [NUM_GRID_MUXES*GW-1:0]      grid_mux_sels,
  output logic [GRID_NUM_ROWS*IW-1:0]       io_mux_sels,
  output logic [NUM_WRITE_PORTS*RW-1:0]     result_mux_sels,
  output logic [GRID_NUM_ROWS-1:0]          rca_io_inp_use
);

  localparam int unsigned RP_IW = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;
  localparam int unsigned WP_IW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;
  localparam int unsigned GM_IW = (NUM_GRID_MUXES > 1) ? $clog2(NUM_GRID_MUXES) : 1;
  localparam int unsigned RO_IW = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;

  localparam logic [2:0] F_SRC      = 3'd0;
  localparam logic [2:0] F_DEST_FB  = 3'd1;
  localparam logic [2:0] F_DEST_NFB = 3'd2;
  localparam logic [2:0] F_GRID     = 3'd3;
  localparam logic [2:0] F_IO       = 3'd4;
  localparam logic [2:0] F_RESULT   = 3'd5;
  localparam logic [2:0] F_IO_USE   = 3'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // One complete context; element 0 of every array sits in the LSBs of the flattened output.
  typedef struct packed {
    logic [NUM_READ_PORTS-1:0][4:0]     src;
    logic [NUM_WRITE_PORTS-1:0][4:0]    dest_fb;
    logic [NUM_WRITE_PORTS-1:0][4:0]    dest_nfb;
    logic [NUM_GRID_MUXES-1:0][GW-1:0]  grid;
    logic [GRID_NUM_ROWS-1:0][IW-1:0]   io;
    logic [NUM_WRITE_PORTS-1:0][RW-1:0] result;
    logic [GRID_NUM_ROWS-1:0]           io_use;
  } cfg_t;

  cfg_t [NUM_RCAS-1:0] sh_q, sh_d;
  cfg_t [NUM_RCAS-1:0] act_q, act_d;
  cfg_t                act_sel;

  logic [0:0]       state_q, state_d;
  logic [RCA_W-1:0] commit_rca_q, commit_rca_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             copy_en;
  logic             wr_fire;
  logic             idx_ok;
  logic [31:0]      idx_w;
  logic             unused_data;

  assign idx_w       = {24'd0, cfg_wr_idx};
  assign unused_data = ^cfg_wr_data;

  assign cfg_wr_ready = !((state_q == S_WAIT) && (cfg_wr_rca == commit_rca_q));
  assign wr_fire      = cfg_wr_valid && cfg_wr_ready;

  always_comb begin
    idx_ok = 1'b0;
    case (cfg_wr_field)
      F_SRC:      idx_ok = idx_w < NUM_READ_PORTS;
      F_DEST_FB:  idx_ok = idx_w < NUM_WRITE_PORTS;
      F_DEST_NFB: idx_ok = idx_w < NUM_WRITE_PORTS;
      F_GRID:     idx_ok = idx_w < NUM_GRID_MUXES;
      F_IO:       idx_ok = idx_w < GRID_NUM_ROWS;
      F_RESULT:   idx_ok = idx_w < NUM_WRITE_PORTS;
      F_IO_USE:   idx_ok = (cfg_wr_idx == 8'd0);
      default:    idx_ok = 1'b0;
    endcase
  end

  always_comb begin
    sh_d  = sh_q;
    err_d = wr_fire && !idx_ok;
    if (wr_fire && idx_ok) begin
      case (cfg_wr_field)
        F_SRC:      sh_d[cfg_wr_rca].src[cfg_wr_idx[RP_IW-1:0]]      = cfg_wr_data[4:0];
        F_DEST_FB:  sh_d[cfg_wr_rca].dest_fb[cfg_wr_idx[WP_IW-1:0]]  = cfg_wr_data[4:0];
        F_DEST_NFB: sh_d[cfg_wr_rca].dest_nfb[cfg_wr_idx[WP_IW-1:0]] = cfg_wr_data[4:0];
        F_GRID:     sh_d[cfg_wr_rca].grid[cfg_wr_idx[GM_IW-1:0]]     = cfg_wr_data[GW-1:0];
        F_IO:       sh_d[cfg_wr_rca].io[cfg_wr_idx[RO_IW-1:0]]       = cfg_wr_data[IW-1:0];
        F_RESULT:   sh_d[cfg_wr_rca].result[cfg_wr_idx[WP_IW-1:0]]   = cfg_wr_data[RW-1:0];
        F_IO_USE:   sh_d[cfg_wr_rca].io_use                          = cfg_wr_data[GRID_NUM_ROWS-1:0];
        default:    sh_d = sh_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    commit_rca_d = commit_rca_q;
    ack_d        = 1'b0;
    copy_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit_req) begin
          state_d      = S_WAIT;
          commit_rca_d = commit_rca;
        end
      end
      S_WAIT: begin
        if (!rca_busy[commit_rca_q]) begin
          state_d = S_IDLE;
          ack_d   = 1'b1;
          copy_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writes to the committing RCA are stalled in WAIT, so shadow[q] is stable for the copy.
  always_comb begin
    act_d = act_q;
    if (copy_en) begin
      act_d[commit_rca_q] = sh_q[commit_rca_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q         <= '0;
      act_q        <= '0;
      state_q      <= S_IDLE;
      commit_rca_q <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sh_q         <= sh_d;
      act_q        <= act_d;
      state_q      <= state_d;
      commit_rca_q <= commit_rca_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign commit_ack  = ack_q;
  assign cfg_wr_err  = err_q;
  assign commit_busy = (state_q == S_WAIT);

  assign act_sel                = act_q[rca_sel];
  assign rca_cpu_src_reg_addrs  = rca_use_fb_instr ? act_sel.src : '0;
  assign rca_cpu_dest_reg_addrs = rca_use_fb_instr ? act_sel.dest_fb : act_sel.dest_nfb;
  assign grid_mux_sels          = act_sel.grid;
  assign io_mux_sels            = act_sel.io;
  assign result_mux_sels        = act_sel.result;
  assign rca_io_inp_use         = act_sel.io_use;

endmodule

// File: tb/tb_rca_config_bank.sv
// Bench for rca_config_bank: an array-based reference of shadow/active contexts and commit state,
// compared every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rca_config_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_wr_valid;
  logic         cfg_wr_ready;
  logic [1:0]   cfg_wr_rca;
  logic [2:0]   cfg_wr_field;
  logic [7:0]   cfg_wr_idx;
  logic [7:0]   cfg_wr_data;
  logic         cfg_wr_err;
  logic         commit_req;
  logic [1:0]   commit_rca;
  logic         commit_ack;
  logic         commit_busy;
  logic [3:0]   rca_busy;
  logic [1:0]   rca_sel;
  logic         rca_use_fb_instr;
  logic [9:0]   rca_cpu_src_reg_addrs;
  logic [9:0]   rca_cpu_dest_reg_addrs;
  logic [95:0]  grid_mux_sels;
  logic [11:0]  io_mux_sels;
  logic [3:0]   result_mux_sels;
  logic [3:0]   rca_io_inp_use;

  rca_config_bank dut (
    .clk(clk), .rst(rst),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready), .cfg_wr_rca(cfg_wr_rca),
    .cfg_wr_field(cfg_wr_field), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_err(cfg_wr_err), .commit_req(commit_req), .commit_rca(commit_rca),
    .commit_ack(commit_ack), .commit_busy(commit_busy), .rca_busy(rca_busy),
    .rca_sel(rca_sel), .rca_use_fb_instr(rca_use_fb_instr),
    .rca_cpu_src_reg_addrs(rca_cpu_src_reg_addrs), .rca_cpu_dest_reg_addrs(rca_cpu_dest_reg_addrs),
    .grid_mux_sels(grid_mux_sels), .io_mux_sels(io_mux_sels),
    .result_mux_sels(result_mux_sels), .rca_io_inp_use(rca_io_inp_use)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Reference contexts: [rca][field][entry], values already truncated to field width.
  logic [7:0] m_sh  [4][7][32];
  logic [7:0] m_act [4][7][32];
  bit         m_wait;
  int         m_crca;
  bit         m_ack;
  bit         m_err;

  function automatic int fwidth(input int f);
    case (f)
      0, 1, 2: return 5;
      3, 4:    return 3;
      5:       return 2;
      6:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int flimit(input int f);
    case (f)
      0:       return 2;
      1, 2:    return 2;
      3:       return 32;
      4:       return 4;
      5:       return 2;
      6:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit n_ack, n_err, rdy;
    int r, f, i;
    if (rst) begin
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 7; b++)
          for (int c = 0; c < 32; c++) begin
            m_sh[a][b][c]  = 8'd0;
            m_act[a][b][c] = 8'd0;
          end
      m_wait = 1'b0; m_crca = 0; m_ack = 1'b0; m_err = 1'b0;
    end else begin
      n_ack = 1'b0; n_err = 1'b0;
      r = int'(cfg_wr_rca); f = int'(cfg_wr_field); i = int'(cfg_wr_idx);
      rdy = !(m_wait && r == m_crca);
      if (cfg_wr_valid && rdy) begin
        if (i < flimit(f)) m_sh[r][f][i] = 8'(int'(cfg_wr_data) & ((1 << fwidth(f)) - 1));
        else n_err = 1'b1;
      end
      if (m_wait) begin
        if (!rca_busy[m_crca]) begin
          for (int b = 0; b < 7; b++)
            for (int c = 0; c < 32; c++) m_act[m_crca][b][c] = m_sh[m_crca][b][c];
          m_wait = 1'b0;
          n_ack  = 1'b1;
        end
      end else if (commit_req) begin
        m_wait = 1'b1;
        m_crca = int'(commit_rca);
      end
      m_ack = n_ack;
      m_err = n_err;
    end
  end

  logic [127:0] e_src, e_dst, e_grid, e_io, e_res, e_use;
  always @(negedge clk) begin
    int s;
    if (cmp_en) begin
      s = int'(rca_sel);
      e_src = '0; e_dst = '0; e_grid = '0; e_io = '0; e_res = '0; e_use = '0;
      for (int p = 0; p < 2; p++) begin
        if (rca_use_fb_instr) e_src[p*5 +: 5] = m_act[s][0][p][4:0];
        e_dst[p*5 +: 5] = rca_use_fb_instr ? m_act[s][1][p][4:0] : m_act[s][2][p][4:0];
        e_res[p*2 +: 2] = m_act[s][5][p][1:0];
      end
      for (int m = 0; m < 32; m++) e_grid[m*3 +: 3] = m_act[s][3][m][2:0];
      for (int q = 0; q < 4; q++) e_io[q*3 +: 3] = m_act[s][4][q][2:0];
      e_use[3:0] = m_act[s][6][0][3:0];
      chk("m_ready", cfg_wr_ready, !(m_wait && int'(cfg_wr_rca) == m_crca));
      chk("m_busy", commit_busy, m_wait);
      chk("m_ack", commit_ack, m_ack);
      chk("m_err", cfg_wr_err, m_err);
      chk("m_src", rca_cpu_src_reg_addrs, e_src);
      chk("m_dest", rca_cpu_dest_reg_addrs, e_dst);
      chk("m_grid", grid_mux_sels, e_grid);
      chk("m_io", io_mux_sels, e_io);
      chk("m_result", result_mux_sels, e_res);
      chk("m_io_use", rca_io_inp_use, e_use);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int r, input int f, input int i, input int d);
    cfg_wr_valid = 1'b1;
    cfg_wr_rca   = 2'(r);
    cfg_wr_field = 3'(f);
    cfg_wr_idx   = 8'(i);
    cfg_wr_data  = 8'(d);
    tick;
    cfg_wr_valid = 1'b0;
  endtask

  task automatic commit(input int r);
    commit_req = 1'b1;
    commit_rca = 2'(r);
    tick;
    commit_req = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int n = 0;
    while (commit_ack !== 1'b1 && n < budget) begin
      tick;
      n++;
    end
    chk("ack_within_budget", (n < budget), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_wr_valid = 1'b0; cfg_wr_rca = '0; cfg_wr_field = '0; cfg_wr_idx = '0;
    cfg_wr_data = '0; commit_req = 1'b0; commit_rca = '0; rca_busy = '0; rca_sel = '0;
    rca_use_fb_instr = 1'b1;
    tick; tick;
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state across every context
    for (int s = 0; s < 4; s++) begin
      rca_sel = 2'(s);
      @(negedge clk);
      chk("rst_grid", grid_mux_sels, 96'd0);
      chk("rst_src", rca_cpu_src_reg_addrs, 10'd0);
      chk("rst_ready", cfg_wr_ready, 1'b1);
      chk("rst_busy", commit_busy, 1'b0);
      tick;
    end

    // Shadow write is invisible until committed
    rca_sel = 2'd1;
    wr(1, 3, 5, 3);
    @(negedge clk);
    chk("t2_pre_commit", grid_mux_sels[17:15], 3'd0);
    tick;
    commit(1);
    @(negedge clk);
    chk("t2_wait_busy", commit_busy, 1'b1);
    chk("t2_wait_noack", commit_ack, 1'b0);
    tick;
    @(negedge clk);
    chk("t2_ack", commit_ack, 1'b1);
    chk("t2_rca1_grid5", grid_mux_sels[17:15], 3'd3);
    chk("t2_model_pin", m_act[1][3][5], 8'd3);
    tick;
    rca_sel = 2'd0;
    @(negedge clk);
    chk("t2_ack_pulse", commit_ack, 1'b0);
    chk("t2_rca0_grid5", grid_mux_sels[17:15], 3'd0);
    tick;

    // Commit held by busy RCA; only that RCA's writes stall
    rca_busy = 4'b0100;
    commit(2);
    for (int i = 0; i < 10; i++) begin
      cfg_wr_valid = 1'b1;
      cfg_wr_rca   = (i % 2) ? 2'd0 : 2'd2;
      cfg_wr_field = 3'd3;
      cfg_wr_idx   = 8'(i);
      cfg_wr_data  = 8'd7;
      @(negedge clk);
      chk("t3_ready", cfg_wr_ready, (i % 2) ? 1'b1 : 1'b0);
      chk("t3_busy", commit_busy, 1'b1);
      tick;
    end
    cfg_wr_valid = 1'b0;
    rca_busy = 4'b0000;
    tick;
    @(negedge clk);
    chk("t3_ack", commit_ack, 1'b1);
    tick;
    rca_sel = 2'd2;
    @(negedge clk);
    chk("t3_rca2_grid_clean", grid_mux_sels, 96'd0);
    tick;
    rca_sel = 2'd0;
    @(negedge clk);
    chk("t3_rca0_active_unchanged", grid_mux_sels, 96'd0);
    tick;

    // Bad index / field flag an error and leave state alone
    wr(0, 0, 2, 9);
    @(negedge clk);
    chk("t4_err_src_idx", cfg_wr_err, 1'b1);
    tick;
    wr(0, 7, 0, 9);
    @(negedge clk);
    chk("t4_err_field7", cfg_wr_err, 1'b1);
    tick;
    wr(0, 6, 1, 15);
    @(negedge clk);
    chk("t4_err_iouse_idx", cfg_wr_err, 1'b1);
    tick;
    wr(0, 3, 2, 8'hFF);
    @(negedge clk);
    chk("t4_good_write_no_err", cfg_wr_err, 1'b0);
    tick;
    commit(0);
    wait_ack(20);
    @(negedge clk);
    chk("t4_src_untouched", rca_cpu_src_reg_addrs, 10'd0);
    chk("t4_grid_idx1", grid_mux_sels[5:3], 3'd7);
    chk("t4_grid_idx2_trunc", grid_mux_sels[8:6], 3'd7);
    chk("t4_io_use_untouched", rca_io_inp_use, 4'd0);
    tick;

    // FB vs NFB destinations; write landing on the commit_req edge is included
    wr(3, 1, 0, 10);
    wr(3, 0, 1, 8'h3F);
    wr(3, 5, 1, 3);
    cfg_wr_valid = 1'b1; cfg_wr_rca = 2'd3; cfg_wr_field = 3'd2; cfg_wr_idx = 8'd0; cfg_wr_data = 8'd20;
    commit_req = 1'b1; commit_rca = 2'd3;
    tick;
    cfg_wr_valid = 1'b0; commit_req = 1'b0;
    wait_ack(20);
    rca_sel = 2'd3; rca_use_fb_instr = 1'b1;
    @(negedge clk);
    chk("t5_fb_dest", rca_cpu_dest_reg_addrs[4:0], 5'd10);
    chk("t5_src_live", rca_cpu_src_reg_addrs, {5'd31, 5'd0});
    chk("t5_result", result_mux_sels, 4'b1100);
    tick;
    rca_use_fb_instr = 1'b0;
    @(negedge clk);
    chk("t5_nfb_dest", rca_cpu_dest_reg_addrs[4:0], 5'd20);
    chk("t5_src_zero", rca_cpu_src_reg_addrs, 10'd0);
    tick;

    // Reset while WAITing aborts the commit and clears active sets
    wr(3, 3, 0, 6);
    rca_busy = 4'b1000;
    commit(3);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rca_busy = 4'b0000;
    @(negedge clk);
    chk("t6_busy_cleared", commit_busy, 1'b0);
    chk("t6_no_ack", commit_ack, 1'b0);
    chk("t6_dest_zero", rca_cpu_dest_reg_addrs, 10'd0);
    tick;
    rca_sel = 2'd1;
    @(negedge clk);
    chk("t6_no_late_ack", commit_ack, 1'b0);
    chk("t6_rca1_zero", grid_mux_sels, 96'd0);
    tick;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
